// File: rtl/jtframe_sdram_sched_if.sv
// Signal bundle between the game/download requesters, the scheduler and the SDRAM engine.
// master = requester + engine side, slave = scheduler.
interface jtframe_sdram_sched_if #(
  parameter int AW = 22
);
  logic            downloading;
  logic            rfsh_en;
  logic [3:0]      ba_rd;
  logic            ba0_wr;
  logic [4*AW-1:0] ba_addr;
  logic [15:0]     ba0_din;
  logic [1:0]      ba0_din_m;
  logic [3:0]      ba_ack;
  logic [3:0]      ba_rdy;
  logic            prog_rd;
  logic            prog_we;
  logic [1:0]      prog_ba;
  logic [AW-1:0]   prog_addr;
  logic [15:0]     prog_din;
  logic [1:0]      prog_mask;
  logic            prog_ack;
  logic            prog_rdy;
  logic            cmd_start;
  logic            cmd_rfsh;
  logic            cmd_wr;
  logic [1:0]      cmd_ba;
  logic [AW-1:0]   cmd_addr;
  logic [15:0]     cmd_din;
  logic [1:0]      cmd_dqm;
  logic            cmd_done;

  modport master (
    output downloading, rfsh_en, ba_rd, ba0_wr, ba_addr, ba0_din, ba0_din_m,
           prog_rd, prog_we, prog_ba, prog_addr, prog_din, prog_mask, cmd_done,
    input  ba_ack, ba_rdy, prog_ack, prog_rdy,
           cmd_start, cmd_rfsh, cmd_wr, cmd_ba, cmd_addr, cmd_din, cmd_dqm
  );

  modport slave (
    input  downloading, rfsh_en, ba_rd, ba0_wr, ba_addr, ba0_din, ba0_din_m,
           prog_rd, prog_we, prog_ba, prog_addr, prog_din, prog_mask, cmd_done,
    output ba_ack, ba_rdy, prog_ack, prog_rdy,
           cmd_start, cmd_rfsh, cmd_wr, cmd_ba, cmd_addr, cmd_din, cmd_dqm
  );
endinterface

// File: rtl/jtframe_sdram_sched.sv
// Single-access SDRAM scheduler: picks one of refresh, download port or the four
// bank ports (round-robin), launches it on the engine and routes ack/rdy back.
module jtframe_sdram_sched #(
  parameter int AW          = 22,
  parameter int RFSH_PERIOD = 750
)(
  input  logic                 clk,
  input  logic                 rst_n,
  jtframe_sdram_sched_if.slave bus
);
  localparam int CW = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;

  typedef enum logic {IDLE, WAIT} state_t;
  state_t r_state, w_state_nx;

  logic [CW-1:0] r_rcnt;
  logic [1:0]    r_pend, r_rr;
  logic          r_gprog, r_start, r_rfsh, r_wr, r_pack, r_prdy;
  logic [3:0]    r_ack, r_rdy;
  logic [1:0]    r_ba, r_dqm;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_din;

  logic          w_gprog, w_start, w_rfsh, w_wr, w_pack, w_prdy;
  logic [3:0]    w_ack, w_rdy;
  logic [1:0]    w_ba, w_dqm, w_rr;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_din;

  logic          w_wrap, w_rfsh_done, w_bgnt, w_bwr;
  logic [3:0]    w_breq;
  logic [1:0]    w_bidx, w_idx;

  // Refresh tokens: one per period, at most three banked up.
  assign w_wrap      = (r_rcnt == CW'(RFSH_PERIOD - 1));
  assign w_rfsh_done = (r_state == WAIT) && bus.cmd_done && r_rfsh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcnt <= '0;
      r_pend <= 2'd0;
    end else begin
      r_rcnt <= w_wrap ? '0 : r_rcnt + CW'(1);
      if (w_wrap && !w_rfsh_done && r_pend != 2'd3) r_pend <= r_pend + 2'd1;
      else if (w_rfsh_done && !w_wrap)              r_pend <= r_pend - 2'd1;
    end
  end

  // A port showing rdy this cycle has not had time to drop its request yet.
  assign w_breq = (bus.ba_rd | {3'b000, bus.ba0_wr}) & ~r_rdy;

  always_comb begin
    w_bgnt = 1'b0;
    w_bidx = r_rr;
    w_idx  = r_rr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_rr + 2'(i);
      if (w_breq[w_idx]) begin
        w_bgnt = 1'b1;
        w_bidx = w_idx;
      end
    end
  end

  assign w_bwr = (w_bidx == 2'd0) && bus.ba0_wr;

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_ack      = 4'b0000;
    w_pack     = 1'b0;
    w_rdy      = 4'b0000;
    w_prdy     = 1'b0;
    w_rfsh     = r_rfsh;
    w_wr       = r_wr;
    w_gprog    = r_gprog;
    w_ba       = r_ba;
    w_addr     = r_addr;
    w_din      = r_din;
    w_dqm      = r_dqm;
    w_rr       = r_rr;
    case (r_state)
      IDLE: begin
        if (r_pend == 2'd3 || (!bus.downloading && r_pend != 2'd0 && bus.rfsh_en)) begin
          w_state_nx = WAIT;
          w_start    = 1'b1;
          w_rfsh     = 1'b1;
          w_wr       = 1'b0;
          w_gprog    = 1'b0;
          w_ba       = 2'd0;
          w_addr     = '0;
          w_din      = 16'h0000;
          w_dqm      = 2'b00;
        end else if (bus.downloading) begin
          if ((bus.prog_rd || bus.prog_we) && !r_prdy) begin
            w_state_nx = WAIT;
            w_start    = 1'b1;
            w_pack     = 1'b1;
            w_rfsh     = 1'b0;
            w_wr       = bus.prog_we;
            w_gprog    = 1'b1;
            w_ba       = bus.prog_ba;
            w_addr     = bus.prog_addr;
            w_din      = bus.prog_we ? bus.prog_din  : 16'h0000;
            w_dqm      = bus.prog_we ? bus.prog_mask : 2'b00;
          end
        end else if (w_bgnt) begin
          w_state_nx = WAIT;
          w_start    = 1'b1;
          w_ack      = 4'b0001 << w_bidx;
          w_rfsh     = 1'b0;
          w_wr       = w_bwr;
          w_gprog    = 1'b0;
          w_ba       = w_bidx;
          w_addr     = bus.ba_addr[w_bidx*AW +: AW];
          w_din      = w_bwr ? bus.ba0_din   : 16'h0000;
          w_dqm      = w_bwr ? bus.ba0_din_m : 2'b00;
          w_rr       = w_bidx + 2'd1;
        end
      end
      WAIT: begin
        if (bus.cmd_done) begin
          w_state_nx = IDLE;
          if (r_gprog)     w_prdy = 1'b1;
          else if (!r_rfsh) w_rdy = 4'b0001 << r_ba;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_ack   <= 4'b0000;
      r_pack  <= 1'b0;
      r_rdy   <= 4'b0000;
      r_prdy  <= 1'b0;
      r_rfsh  <= 1'b0;
      r_wr    <= 1'b0;
      r_gprog <= 1'b0;
      r_ba    <= 2'd0;
      r_addr  <= '0;
      r_din   <= 16'h0000;
      r_dqm   <= 2'b00;
      r_rr    <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_start <= w_start;
      r_ack   <= w_ack;
      r_pack  <= w_pack;
      r_rdy   <= w_rdy;
      r_prdy  <= w_prdy;
      r_rfsh  <= w_rfsh;
      r_wr    <= w_wr;
      r_gprog <= w_gprog;
      r_ba    <= w_ba;
      r_addr  <= w_addr;
      r_din   <= w_din;
      r_dqm   <= w_dqm;
      r_rr    <= w_rr;
    end
  end

  assign bus.cmd_start = r_start;
  assign bus.cmd_rfsh  = r_rfsh;
  assign bus.cmd_wr    = r_wr;
  assign bus.cmd_ba    = r_ba;
  assign bus.cmd_addr  = r_addr;
  assign bus.cmd_din   = r_din;
  assign bus.cmd_dqm   = r_dqm;
  assign bus.ba_ack    = r_ack;
  assign bus.ba_rdy    = r_rdy;
  assign bus.prog_ack  = r_pack;
  assign bus.prog_rdy  = r_prdy;
endmodule
